// File: rtl/shift_seq.sv
// Multi-cycle 32-bit shifter: five conditional power-of-two steps (1,2,4,8,16)
// selected by the captured shift-amount bits, with a valid/ready handshake on each side.
module shift_seq #(
   parameter bit EARLY_ZERO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [4:0]  shamt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

   state_t      state, state_n;
   logic [2:0]  k;
   logic [1:0]  op_q;
   logic [4:0]  amt_q;
   logic        sign_q;
   logic [31:0] work, work_n, res;
   logic        accept, zero_skip;

   // One step shifts by 2^kk; SAR fills from the captured sign, not the working MSB.
   function automatic logic [31:0] shift_by(input logic [31:0] v, input logic [1:0] o,
                                            input logic s, input logic [2:0] kk);
      logic [4:0] n;
      n = 5'd1 << kk;
      case (o)
         2'b00:   return v << n;
         2'b01:   return v >> n;
         2'b10:   return (v >> n) | (s ? ~(32'hFFFF_FFFF >> n) : 32'h0);
         default: return (v << n) | (v >> (6'd32 - {1'b0, n}));
      endcase
   endfunction

   assign accept    = in_valid && in_ready;
   assign zero_skip = EARLY_ZERO && (shamt == 5'd0);
   assign work_n    = amt_q[k] ? shift_by(work, op_q, sign_q, k) : work;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign result    = res;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = zero_skip ? DONE : STEP;
         STEP:    if (k == 3'd4) state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k      <= 3'd0;
         op_q   <= 2'b00;
         amt_q  <= 5'd0;
         sign_q <= 1'b0;
         work   <= 32'h0;
         res    <= 32'h0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               k      <= 3'd0;
               op_q   <= op;
               amt_q  <= shamt;
               sign_q <= a[31];
               work   <= a;
               if (zero_skip) res <= a;
            end
            STEP: begin
               work <= work_n;
               // result only moves when the last step lands, so it holds through STEP
               if (k == 3'd4) begin
                  res <= work_n;
                  k   <= 3'd0;
               end else begin
                  k <= k + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter EARLY_ZERO, default 0; when 1, a zero shift amount completes without the shift steps.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: request present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port op, input, 2 bits: 00 SHL (zero fill), 01 SHR (zero fill), 10 SAR (sign fill), 11 ROL (rotate left).
REQ-007 SHALL have port a, input, 32 bits: operand.
REQ-008 SHALL have port shamt, input, 5 bits: shift amount 0..31.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port result, output, 32 bits: shifted value.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, STEP and DONE.
REQ-014 IDLE SHALL drive in_ready=1; in every other state in_ready SHALL be 0.
REQ-015 Accept SHALL occur when in_valid&&in_ready at a clock edge; a, op and shamt SHALL be captured into internal registers on that edge.
REQ-016 On accept the FSM SHALL go IDLE->STEP with step counter k=0, except as in REQ-020.
REQ-017 STEP SHALL, once per cycle, replace the working value with its shift by 2^k when captured shamt[k]=1, and hold it when shamt[k]=0.
REQ-018 STEP SHALL increment k each cycle; after k=4 it SHALL go to DONE.
REQ-019 Latency SHALL be fixed: out_valid rises exactly 5 cycles after the accept edge, independent of shamt and op.
REQ-020 With EARLY_ZERO=1 and shamt=0, accept SHALL go directly to DONE with result=a, giving out_valid 1 cycle after accept.
REQ-021 Fill rules SHALL be:
- SHL: zeros enter at bit 0.
- SHR: zeros enter at bit 31.
- SAR: copies of the captured a[31] enter at bit 31.
- ROL: bits shifted out of bit 31 re-enter at bit 0.
REQ-022 All results SHALL be exactly 32 bits; shamt SHALL never be interpreted beyond 5 bits.
REQ-023 DONE SHALL drive out_valid=1 with result equal to the working register.
REQ-024 result and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 On out_valid&&out_ready the FSM SHALL go DONE->IDLE; in_ready SHALL be 1 in the following cycle, with no same-cycle accept (no bypass).
REQ-026 result SHALL hold its last value in IDLE and STEP; only the working register changes during STEP.
REQ-027 Changes on a, op or shamt after accept SHALL NOT affect the operation in flight.
REQ-028 in_valid asserted while busy SHALL be ignored and SHALL NOT be captured.

Reset
REQ-029 With rst=1 at a clock edge the block SHALL enter IDLE with k=0, result=0x00000000, working register=0, out_valid=0, busy=0 and in_ready=1 after that edge.
REQ-030 Reset SHALL override any accept or output handshake occurring in the same cycle.
REQ-031 Reset asserted during STEP or DONE SHALL abort the operation; no out_valid pulse SHALL follow.
REQ-032 While rst=1, in_valid SHALL be ignored.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- SHL a=0x00000001, shamt=31 -> result=0x80000000, out_valid exactly 5 cycles after accept.
- SAR a=0x80000000, shamt=4 -> 0xF8000000; SHR with the same a and shamt -> 0x08000000.
- ROL a=0x80000001, shamt=1 -> 0x00000003; SHR a=0xFFFFFFFF, shamt=16 -> 0x0000FFFF.
- out_ready held 0 for 3 cycles in DONE -> result stable, in_ready=0, second in_valid not accepted; IDLE and in_ready=1 the cycle after the handshake.
- rst pulsed at the 2nd STEP cycle -> next cycle IDLE, result=0, no out_valid.
- shamt=0, a=0x12345678: with EARLY_ZERO=0 -> result=0x12345678 after 5 cycles; with EARLY_ZERO=1 -> after 1 cycle.
